// File: rtl/pwm_multichannel_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multichannel_gen_if
// Description : Bundle of button, channel-select, mode, PWM output and
//               duty-readback signals for the multi-channel PWM generator.
//               slave  : the generator side (buttons in, PWM out).
//               master : the controlling side (testbench / UI logic).
// Signals     : btn_inc, btn_dec  raw asynchronous buttons
//               ch_sel            channel targeted by button steps
//               center_mode       0 = edge-aligned, 1 = center-aligned
//               pwm_out           registered PWM outputs, one per channel
//               period_start      one-cycle pulse with the count-0 sample
//               duty_rd           shadow duty of the selected channel
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_multichannel_gen_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 8
);
    localparam int c_SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                btn_inc;
    logic                btn_dec;
    logic [c_SEL_W-1:0]  ch_sel;
    logic                center_mode;
    logic [CHANNELS-1:0] pwm_out;
    logic                period_start;
    logic [WIDTH:0]      duty_rd;

    modport master (
        output btn_inc,
        output btn_dec,
        output ch_sel,
        output center_mode,
        input  pwm_out,
        input  period_start,
        input  duty_rd
    );

    modport slave (
        input  btn_inc,
        input  btn_dec,
        input  ch_sel,
        input  center_mode,
        output pwm_out,
        output period_start,
        output duty_rd
    );
endinterface
`default_nettype wire

// File: rtl/pwm_multichannel_gen.sv
`default_nettype none
// ============================================================================
// Module      : pwm_multichannel_gen
// Description : Multi-channel PWM generator. Debounced increase/decrease
//               buttons step a saturating per-channel shadow duty; shadow
//               duties (and the alignment mode) are copied to the active set
//               only at the period boundary so every pulse is glitch-free.
//               Edge-aligned (period 2^WIDTH) or center-aligned
//               (period 2^(WIDTH+1)-2) counting.
// Ports       : clk  - single clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - pwm_multichannel_gen_if.slave (buttons, ch_sel,
//                      center_mode in; pwm_out, period_start, duty_rd out)
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_multichannel_gen #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 8,
    parameter int STEP       = 16,
    parameter int DEB_CYCLES = 1000,
    parameter int DUTY_INIT  = 128
) (
    input  wire logic             clk,
    input  wire logic             rst,
    pwm_multichannel_gen_if.slave bus
);

    localparam int c_SEL_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_DUTY_W = WIDTH + 1;
    localparam int c_DEB_W  = $clog2(DEB_CYCLES + 1);

    localparam logic [WIDTH-1:0]    c_CNT_MAX   = '1;
    localparam logic [WIDTH-1:0]    c_CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [c_DUTY_W-1:0] c_DUTY_MAX  = {1'b1, {WIDTH{1'b0}}};
    localparam logic [c_DUTY_W-1:0] c_DUTY_INIT = c_DUTY_W'(DUTY_INIT);
    localparam logic [c_DUTY_W-1:0] c_STEP_D    = c_DUTY_W'(STEP);
    localparam logic [WIDTH+1:0]    c_STEP_W    = (WIDTH+2)'(STEP);
    localparam logic [WIDTH+1:0]    c_DMAX_W    = {1'b0, c_DUTY_MAX};
    localparam logic [c_DEB_W-1:0]  c_DEB_LAST  = c_DEB_W'(DEB_CYCLES - 1);
    localparam logic [c_DEB_W-1:0]  c_DEB_ONE   = c_DEB_W'(1);

    // Counter direction state
    localparam logic [0:0] c_DIR_UP   = 1'b0;
    localparam logic [0:0] c_DIR_DOWN = 1'b1;

    // ------------------------------------------------------------------
    // Period counter
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_cnt;
    logic [0:0]       r_dir;
    logic             r_mode_active;
    logic             w_period_end;

    // Edge mode ends on the top count; center mode ends on count 1 on the
    // way down, so the restart at 0 is never repeated.
    assign w_period_end = r_mode_active ? ((r_dir == c_DIR_DOWN) && (r_cnt == c_CNT_ONE))
                                        : (r_cnt == c_CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt         <= '0;
            r_dir         <= c_DIR_UP;
            r_mode_active <= 1'b0;
        end else if (w_period_end) begin
            r_cnt         <= '0;
            r_dir         <= c_DIR_UP;
            r_mode_active <= bus.center_mode;
        end else if (r_dir == c_DIR_UP) begin
            if (r_cnt == c_CNT_MAX) begin
                r_dir <= c_DIR_DOWN;
                r_cnt <= r_cnt - c_CNT_ONE;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end else begin
            r_cnt <= r_cnt - c_CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Button synchronizers and debouncers: bit 0 = inc, bit 1 = dec
    // ------------------------------------------------------------------
    logic [1:0] w_raw;
    logic [1:0] w_pulse;

    assign w_raw = {bus.btn_dec, bus.btn_inc};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic               r_sync1;
        logic               r_sync2;
        logic               r_level;
        logic               r_level_q;
        logic [c_DEB_W-1:0] r_deb_cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync1   <= 1'b0;
                r_sync2   <= 1'b0;
                r_level   <= 1'b0;
                r_level_q <= 1'b0;
                r_deb_cnt <= '0;
            end else begin
                r_sync1   <= w_raw[b];
                r_sync2   <= r_sync1;
                r_level_q <= r_level;
                // Any sample that agrees with the accepted level restarts
                // the run, so short bounces never accumulate.
                if (r_sync2 != r_level) begin
                    if (r_deb_cnt == c_DEB_LAST) begin
                        r_level   <= r_sync2;
                        r_deb_cnt <= '0;
                    end else begin
                        r_deb_cnt <= r_deb_cnt + c_DEB_ONE;
                    end
                end else begin
                    r_deb_cnt <= '0;
                end
            end
        end

        // Rising edge of the accepted level only; releases make no pulse.
        assign w_pulse[b] = r_level & ~r_level_q;
    end

    // ------------------------------------------------------------------
    // Duty registers and step arithmetic
    // ------------------------------------------------------------------
    logic [c_DUTY_W-1:0] r_shadow [CHANNELS];
    logic [c_DUTY_W-1:0] r_active [CHANNELS];
    logic [CHANNELS-1:0] w_sel_hit;
    logic [c_DUTY_W-1:0] w_sel_duty;
    logic [WIDTH+1:0]    w_sel_wide;
    logic [WIDTH+1:0]    w_inc_val;
    logic [c_DUTY_W-1:0] w_step_duty;
    logic                w_inc;
    logic                w_dec;

    // Simultaneous inc and dec cancel out.
    assign w_inc = w_pulse[0] & ~w_pulse[1];
    assign w_dec = w_pulse[1] & ~w_pulse[0];

    // Out-of-range ch_sel matches no channel: reads 0 and steps nothing.
    always_comb begin
        w_sel_hit  = '0;
        w_sel_duty = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.ch_sel == c_SEL_W'(c)) begin
                w_sel_hit[c] = 1'b1;
                w_sel_duty   = r_shadow[c];
            end
        end
    end

    assign w_sel_wide = {1'b0, w_sel_duty};
    assign w_inc_val  = w_sel_wide + c_STEP_W;

    always_comb begin
        w_step_duty = w_sel_duty;
        if (w_inc) begin
            w_step_duty = (w_inc_val > c_DMAX_W) ? c_DUTY_MAX : w_inc_val[WIDTH:0];
        end else if (w_dec) begin
            // No underflow here, so the subtraction fits in duty width.
            w_step_duty = (w_sel_wide < c_STEP_W) ? '0 : (w_sel_duty - c_STEP_D);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_shadow[c] <= c_DUTY_INIT;
                r_active[c] <= c_DUTY_INIT;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (w_period_end) begin
                    r_active[c] <= r_shadow[c];
                end
                if ((w_inc || w_dec) && w_sel_hit[c]) begin
                    r_shadow[c] <= w_step_duty;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    logic [CHANNELS-1:0] r_pwm;
    logic                r_period_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm          <= '0;
            r_period_start <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_pwm[c] <= ({1'b0, r_cnt} < r_active[c]);
            end
            r_period_start <= (r_cnt == '0);
        end
    end

    assign bus.pwm_out      = r_pwm;
    assign bus.period_start = r_period_start;
    assign bus.duty_rd      = w_sel_duty;

endmodule
`default_nettype wire
